// File: rtl/ysyx_25020047_lsu_pkg.sv
`timescale 1ns/1ps
// ysyx_25020047_lsu_pkg
// Shared encodings for the multi-cycle LSU: access sizes, response error
// codes and the transaction FSM states.
package ysyx_25020047_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MIS = 2'd1;
  localparam logic [1:0] ERR_BUS = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
`timescale 1ns/1ps
// ysyx_25020047_lsu_align
// Combinational lane logic shared by stores and loads.
//   size, uns, off      : access size, zero-extend flag, byte offset in word
//   st_data             : LSB-aligned store data
//   st_wdata, st_wstrb  : store data / byte strobe shifted to the byte lane
//   ld_raw              : full aligned read word from memory
//   ld_data             : selected lane(s), sign- or zero-extended
module ysyx_25020047_lsu_align
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]                  size,
  input  logic                        uns,
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [DATA_W-1:0]           st_data,
  output logic [DATA_W-1:0]           st_wdata,
  output logic [DATA_W/8-1:0]         st_wstrb,
  input  logic [DATA_W-1:0]           ld_raw,
  output logic [DATA_W-1:0]           ld_data
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [STRB_W-1:0] strb_base;
  logic [DATA_W-1:0] ld_sh;
  logic [DATA_W-1:0] keep;
  logic              sbit;
  int unsigned       nbits;

  always_comb begin
    // 1/3/F/FF; a dword base collapses to all-ones on a 32-bit bus
    strb_base = STRB_W'((32'd1 << (32'd1 << size)) - 32'd1);
    st_wstrb  = strb_base << off;
    st_wdata  = st_data << {off, 3'b000};

    ld_sh = ld_raw >> {off, 3'b000};
    nbits = 32'd8 << size;
    keep  = (nbits >= DATA_W) ? '1 : ((DATA_W'(1) << nbits) - DATA_W'(1));
    case (size)
      SZ_B:    sbit = ld_sh[7];
      SZ_H:    sbit = ld_sh[15];
      SZ_W:    sbit = ld_sh[31];
      default: sbit = ld_sh[DATA_W-1];
    endcase
    ld_data = (ld_sh & keep) | ({DATA_W{~uns & sbit}} & ~keep);
  end

endmodule

// File: rtl/ysyx_25020047_lsu_mc.sv
`timescale 1ns/1ps
// ysyx_25020047_lsu_mc
// Multi-cycle load/store unit between EXU and the data-memory port.
//   req_*  : EXU request handshake (we, size, unsigned, addr, wdata)
//   resp_* : WBU result handshake (extended load data, error code)
//   mem_*  : memory request (valid/ready) and response (rvalid/rdata/rerr)
// One transaction at a time; misaligned requests answer without touching
// memory, and a wait of 2^TMO_W-1 cycles ends the access with a timeout.
module ysyx_25020047_lsu_mc
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TMO_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rerr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  // Last count value before the timeout fires: 2^TMO_W-1 waiting cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  lsu_state_e        state_q, state_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              latch, rsp_set, done, mis, in_req;
  logic [DATA_W-1:0] ld_data, st_wdata;
  logic [STRB_W-1:0] st_wstrb;

  ysyx_25020047_lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size    (size_q),
    .uns     (uns_q),
    .off     (addr_q[OFF_W-1:0]),
    .st_data (wdata_q),
    .st_wdata(st_wdata),
    .st_wstrb(st_wstrb),
    .ld_raw  (mem_rdata),
    .ld_data (ld_data)
  );

  always_comb begin
    case (req_size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = req_addr[0];
      SZ_W:    mis = |req_addr[1:0];
      default: mis = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    rsp_set    = 1'b0;
    rdata_d    = '0;
    err_d      = ERR_OK;
    done       = 1'b0;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch = 1'b1;
          cnt_d = '0;
          if (mis) begin
            state_d = S_RESP;
            rsp_set = 1'b1;
            err_d   = ERR_MIS;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ, S_WAIT: begin
        mem_valid = (state_q == S_REQ);
        done      = (state_q == S_REQ) ? (mem_ready & mem_rvalid) : mem_rvalid;
        // A response in the same cycle as the final count still completes.
        if (done) begin
          state_d = S_RESP;
          rsp_set = 1'b1;
          err_d   = mem_rerr ? ERR_BUS : ERR_OK;
          rdata_d = (!we_q && !mem_rerr) ? ld_data : '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_RESP;
          rsp_set = 1'b1;
          err_d   = ERR_TMO;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == S_REQ && mem_ready) state_d = S_WAIT;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      cnt_q <= cnt_d;
      if (latch) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (rsp_set) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign in_req     = (state_q == S_REQ);
  assign mem_we     = in_req & we_q;
  assign mem_addr   = in_req ? (addr_q & ~ADDR_W'(STRB_W - 1)) : '0;
  assign mem_wdata  = in_req ? st_wdata : '0;
  assign mem_wstrb  = in_req ? st_wstrb : '0;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu_mc.sv
`timescale 1ns/1ps
module tb_ysyx_25020047_lsu_mc;

  localparam int TMO_CYC = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid, mem_rerr;

  ysyx_25020047_lsu_mc #(
    .DATA_W(32),
    .ADDR_W(32),
    .TMO_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rerr    (mem_rerr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model expectations for the current clock period.
  logic        chk_en = 1'b0, chk_zero = 1'b0;
  logic        exp_req_ready, exp_mem_valid, exp_resp_valid, exp_we;
  logic [31:0] exp_maddr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  logic [1:0]  exp_err;

  logic [31:0] cap_maddr, cap_wdata, cap_rdata;
  logic [3:0]  cap_wstrb;
  logic [1:0]  cap_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] word);
    int unsigned off, nb;
    logic [63:0] v, mask;
    off  = addr[1:0];
    nb   = 8 << size;
    v    = 64'(word) >> (8 * off);
    mask = (64'd1 << nb) - 64'd1;
    v    = v & mask;
    if (!uns && ((v >> (nb - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, exp_req_ready);
      chk("mem_valid", mem_valid, exp_mem_valid);
      chk("resp_valid", resp_valid, exp_resp_valid);
      if (exp_mem_valid) begin
        chk("mem_addr", mem_addr, exp_maddr);
        chk("mem_we", mem_we, exp_we);
        chk("mem_wstrb", mem_wstrb, exp_wstrb);
        chk("mem_wdata", mem_wdata, exp_wdata);
        cap_maddr = mem_addr;
        cap_wstrb = mem_wstrb;
        cap_wdata = mem_wdata;
      end
      if (exp_resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", resp_err, exp_err);
        if (resp_ready) begin
          cap_rdata = resp_rdata;
          cap_err   = resp_err;
        end
      end
      if (chk_zero) begin
        chk("zero_mem_we", mem_we, 0);
        chk("zero_mem_addr", mem_addr, 0);
        chk("zero_mem_wdata", mem_wdata, 0);
        chk("zero_mem_wstrb", mem_wstrb, 0);
        chk("zero_resp_rdata", resp_rdata, 0);
        chk("zero_resp_err", resp_err, 0);
      end
    end
  end

  // Memory answers at fixed delays after acceptance: mem_ready in period
  // ready_lat+1, mem_rvalid rv_lat periods after that. The WBU accepts the
  // response hold periods after it appears.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic rerr,
                         input int ready_lat, input int rv_lat, input int hold);
    int unsigned off, nbytes;
    logic mis, tmo;
    int k, rc, mv_last;
    off     = addr[1:0];
    nbytes  = 1 << size;
    mis     = (size == 2'd3) || ((addr % nbytes) != 0);
    k       = ready_lat + 1 + rv_lat;
    tmo     = !mis && (k > TMO_CYC);
    rc      = mis ? 1 : (tmo ? TMO_CYC + 1 : k + 1);
    mv_last = mis ? 0 : ((ready_lat + 1 < TMO_CYC) ? ready_lat + 1 : TMO_CYC);

    exp_we    = we;
    exp_maddr = {addr[31:2], 2'b00};
    exp_wstrb = 4'(((1 << nbytes) - 1) << off);
    exp_wdata = 32'(64'(wdata) << (8 * off));
    exp_err   = mis ? 2'd1 : (tmo ? 2'd3 : (rerr ? 2'd2 : 2'd0));
    exp_rdata = (exp_err != 2'd0 || we) ? 32'd0 : ext_load(size, uns, addr, rdata);

    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    exp_req_ready  = 1'b1;
    exp_mem_valid  = 1'b0;
    exp_resp_valid = 1'b0;
    @(posedge clk); #1;

    for (int c = 1; c <= rc + hold + 1; c++) begin
      // Garbage on the request side must be neither latched nor accepted.
      req_valid    = (c <= rc + hold) ? 1'($urandom) : 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      mem_ready    = !mis && (c == ready_lat + 1);
      mem_rvalid   = !mis && (c == k);
      mem_rdata    = (c == k) ? rdata : $urandom;
      mem_rerr     = (c == k) ? rerr : 1'($urandom);
      resp_ready   = (c == rc + hold);
      exp_req_ready  = (c == rc + hold + 1);
      exp_mem_valid  = (c <= mv_last);
      exp_resp_valid = (c >= rc) && (c <= rc + hold);
      @(posedge clk); #1;
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
    exp_req_ready = 1'b1; exp_mem_valid = 1'b0; exp_resp_valid = 1'b0;
    exp_we = 1'b0; exp_maddr = '0; exp_wdata = '0; exp_wstrb = '0;
    exp_rdata = '0; exp_err = '0;
    chk_zero = 1'b1;
    chk_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero = 1'b0;

    // sw aligned
    run_txn(1'b1, 2'd2, 1'b0, 32'h8000_0104, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1, 0);
    chk("lit_sw_addr", cap_maddr, 32'h8000_0104);
    chk("lit_sw_wstrb", cap_wstrb, 4'hF);
    chk("lit_sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("lit_sw_err", cap_err, 2'd0);
    chk("lit_sw_rdata", cap_rdata, 32'h0);

    // sb to the top byte lane
    run_txn(1'b1, 2'd0, 1'b0, 32'h8000_0103, 32'h0000_00A5, 32'h0, 1'b0, 1, 0, 1);
    chk("lit_sb_wstrb", cap_wstrb, 4'h8);
    chk("lit_sb_wdata", cap_wdata, 32'hA500_0000);
    chk("lit_sb_addr", cap_maddr, 32'h8000_0100);

    // lb / lbu / lhu lane extraction, minimum latency
    run_txn(1'b0, 2'd0, 1'b0, 32'h8000_0102, 32'h0, 32'h12F0_3456, 1'b0, 0, 0, 0);
    chk("lit_lb", cap_rdata, 32'hFFFF_FFF0);
    run_txn(1'b0, 2'd0, 1'b1, 32'h8000_0102, 32'h0, 32'h12F0_3456, 1'b0, 0, 0, 0);
    chk("lit_lbu", cap_rdata, 32'h0000_00F0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h8000_0102, 32'h0, 32'h12F0_3456, 1'b0, 0, 2, 0);
    chk("lit_lhu", cap_rdata, 32'h0000_12F0);

    // misaligned word load: no memory access
    run_txn(1'b0, 2'd2, 1'b0, 32'h8000_0102, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    chk("lit_mis_err", cap_err, 2'd1);

    // timeout with mem_ready never raised
    run_txn(1'b0, 2'd2, 1'b0, 32'h8000_0200, 32'h0, 32'h1234_5678, 1'b0, 400, 0, 0);
    chk("lit_tmo_err", cap_err, 2'd3);

    // timeout in WAIT, late mem_rvalid arrives during RESP
    run_txn(1'b0, 2'd2, 1'b0, 32'h8000_0204, 32'h0, 32'hCAFE_F00D, 1'b0, 253, 10, 12);
    chk("lit_tmo_late_err", cap_err, 2'd3);
    run_txn(1'b0, 2'd2, 1'b0, 32'h8000_0208, 32'h0, 32'h0BAD_CAFE, 1'b0, 0, 1, 0);
    chk("lit_after_tmo", cap_rdata, 32'h0BAD_CAFE);

    // response on the last cycle before the timeout
    run_txn(1'b0, 2'd2, 1'b0, 32'h8000_020C, 32'h0, 32'h5555_AAAA, 1'b0, 0, 254, 0);
    chk("lit_edge_err", cap_err, 2'd0);

    // bus error, response held for 5 cycles
    run_txn(1'b0, 2'd2, 1'b0, 32'h8000_0210, 32'h0, 32'hFFFF_FFFF, 1'b1, 0, 1, 5);
    chk("lit_bus_err", cap_err, 2'd2);
    chk("lit_bus_rdata", cap_rdata, 32'h0);

    // reset while waiting on memory
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8000_0300; req_wdata = 32'h1122_3344;
    exp_we = 1'b0; exp_maddr = 32'h8000_0300; exp_wstrb = 4'hF; exp_wdata = 32'h1122_3344;
    exp_req_ready = 1'b1; exp_mem_valid = 1'b0; exp_resp_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    exp_req_ready = 1'b0; exp_mem_valid = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; exp_mem_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; exp_req_ready = 1'b1; chk_zero = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    chk_zero = 1'b0;

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [1:0]  sz;
      logic [31:0] a;
      r  = int'($urandom_range(0, 15));
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      a  = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
              ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
